// File: rtl/biquad8_coeff_loader.sv
// Wishbone master that replays a locally stored coefficient table into the biquad control
// port and finishes with a commit write. Optional per-transaction ack timeout: BIQUAD8_LOADER_TIMEOUT_EN.
module biquad8_coeff_loader #(
  parameter int         NENTRY     = 32,
  parameter int         TIMEOUT    = 255,
  parameter logic [6:0] UPDATE_ADR = 7'h00,
  localparam int        LOG2N      = $clog2(NENTRY)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             tbl_wr_i,
  input  logic [LOG2N-1:0] tbl_adr_i,
  input  logic [24:0]      tbl_dat_i,
  input  logic             start_i,
  input  logic [LOG2N:0]   len_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [6:0]       wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t           state;
  logic [LOG2N-1:0] idx;
  logic [LOG2N:0]   len;
  logic [24:0]      mem [NENTRY];
  logic [24:0]      rd_q;
  logic [LOG2N:0]   len_clamped;
  logic             last_entry;
  logic             tmo_hit;
  logic             rsp_fail;

  assign wb_sel_o = 4'hF;

  // Clamp the requested length to the table depth
  always_comb begin
    len_clamped = len_i;
    if (len_i > (LOG2N+1)'(NENTRY)) begin
      len_clamped = (LOG2N+1)'(NENTRY);
    end else begin
      len_clamped = len_i;
    end
  end

  assign last_entry = ({1'b0, idx} == (len - (LOG2N+1)'(1)));
  assign rsp_fail   = wb_err_i || tmo_hit;

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = wb_cyc_o && (tmo_cnt == TW'(TIMEOUT - 1));

  // Count cycles a bus transaction has been outstanding without a response
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (!wb_cyc_o || wb_ack_i || wb_err_i) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Coefficient table: no reset so contents survive wb_rst_i; writes only while idle
  always_ff @(posedge wb_clk_i) begin
    if (tbl_wr_i && (state == IDLE)) begin
      mem[tbl_adr_i] <= tbl_dat_i;
    end
    if (state == FETCH) begin
      rd_q <= mem[idx];
    end
  end

  // Sequencer: WRITE/COMMIT use the first cycle (cyc still low) to launch the bus cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 7'h00;
      wb_dat_o <= 32'h0000_0000;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            err_o  <= 1'b0;
            busy_o <= 1'b1;
            len    <= len_clamped;
            idx    <= '0;
            state  <= (len_clamped == '0) ? COMMIT : FETCH;
          end
        end
        FETCH: begin
          state <= WRITE;
        end
        WRITE: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= rd_q[24:18];
            wb_dat_o <= {14'b0, rd_q[17:0]};
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state    <= GAP;
          end else if (rsp_fail) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_o    <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        GAP: begin
          if (last_entry) begin
            state <= COMMIT;
          end else begin
            idx   <= idx + LOG2N'(1);
            state <= FETCH;
          end
        end
        COMMIT: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= UPDATE_ADR;
            wb_dat_o <= 32'h0000_0001;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else if (rsp_fail) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_o    <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader: Wishbone target model with configurable ack delay,
// error injection and no-ack mode; one task per scenario with inline checks.
module tb_biquad8_coeff_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_wr = 1'b0;
  logic [4:0]  tbl_adr = 5'd0;
  logic [24:0] tbl_dat = 25'd0;
  logic        start = 1'b0;
  logic [5:0]  len_in = 6'd0;
  logic        cyc, stb, we;
  logic [6:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        busy, done, errflag;

  int tests_run = 0;
  int tests_failed = 0;

  // target model configuration (written by tasks) and state (written by responder)
  int delay = 1;
  int no_ack = 0;
  int err_at = -1;
  int seen = 0;
  int ntx = 0;
  int nwr = 0;
  int ndone = 0;
  logic [6:0]  log_adr [0:255];
  logic [31:0] log_dat [0:255];

  always #5 clk = ~clk;

  biquad8_coeff_loader #(.NENTRY(32), .TIMEOUT(16), .UPDATE_ADR(7'h00)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .tbl_wr_i(tbl_wr), .tbl_adr_i(tbl_adr), .tbl_dat_i(tbl_dat),
    .start_i(start), .len_i(len_in),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel),
    .wb_ack_i(ack), .wb_err_i(err),
    .busy_o(busy), .done_o(done), .err_o(errflag)
  );

  // Target: responds on the (delay+1)-th cycle of a bus cycle, logs acked writes
  always @(negedge clk) begin
    if (done === 1'b1) ndone = ndone + 1;
    if (rst) begin
      ack = 1'b0; err = 1'b0; seen = 0;
    end else if (cyc && stb && !ack && !err) begin
      seen = seen + 1;
      if (no_ack == 0 && seen == delay + 1) begin
        if (ntx == err_at) begin
          err = 1'b1;
        end else begin
          ack = 1'b1;
          if (nwr < 256) begin
            log_adr[nwr] = adr;
            log_dat[nwr] = dat;
          end
          nwr = nwr + 1;
        end
        ntx = ntx + 1;
        seen = 0;
      end
    end else if (!(cyc && stb)) begin
      ack = 1'b0; err = 1'b0; seen = 0;
    end
  end

  task automatic load_entry(input logic [4:0] a, input logic [24:0] d);
    tbl_wr = 1'b1; tbl_adr = a; tbl_dat = d;
    @(negedge clk);
    tbl_wr = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] l);
    start = 1'b1; len_in = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if ({cyc, stb, we} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 000", {cyc, stb, we}); end
    tests_run++; if (adr !== 7'h00 || dat !== 32'h0) begin tests_failed++; $display("FAIL reset_adr_dat: got %h/%h expected 00/00000000", adr, dat); end
    tests_run++; if ({busy, done, errflag} !== 3'b000) begin tests_failed++; $display("FAIL reset_status: got %b expected 000", {busy, done, errflag}); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || cyc !== 1'b0) begin tests_failed++; $display("FAIL reset_release: busy=%b cyc=%b expected 0/0", busy, cyc); end
  endtask

  task automatic test_basic;
    int b, d0, n;
    logic ok;
    logic [6:0]  ea [4];
    logic [31:0] ed [4];
    ea = '{7'h04, 7'h08, 7'h10, 7'h00};
    ed = '{32'h0000_0123, 32'h0003_FFFF, 32'h0000_0001, 32'h0000_0001};
    load_entry(5'd0, {7'h04, 18'h00123});
    load_entry(5'd1, {7'h08, 18'h3FFFF});
    load_entry(5'd2, {7'h10, 18'h00001});
    delay = 4; b = nwr; d0 = ndone;
    do_start(6'd3);
    tests_run++; if (busy !== 1'b1 || cyc !== 1'b0) begin tests_failed++; $display("FAIL basic_k0: busy=%b cyc=%b expected 1/0", busy, cyc); end
    @(negedge clk);
    tests_run++; if (cyc !== 1'b0) begin tests_failed++; $display("FAIL basic_k1_cyc: got %b expected 0", cyc); end
    @(negedge clk);
    tests_run++; if ({cyc, stb, we} !== 3'b111 || sel !== 4'hF) begin tests_failed++; $display("FAIL basic_k2_strobes: got %b sel %h expected 111 sel f", {cyc, stb, we}, sel); end
    tests_run++; if (adr !== 7'h04 || dat !== 32'h0000_0123) begin tests_failed++; $display("FAIL basic_first_bus: got %h/%h expected 04/00000123", adr, dat); end
    n = 2;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (n !== 30) begin tests_failed++; $display("FAIL basic_done_latency: got %0d expected 30", n); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_width: got %b expected 0", done); end
    wait_idle(ok);
    tests_run++; if (nwr - b !== 4) begin tests_failed++; $display("FAIL basic_write_count: got %0d expected 4", nwr - b); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (log_adr[b+i] !== ea[i] || log_dat[b+i] !== ed[i]) begin tests_failed++; $display("FAIL basic_write_%0d: got %h/%h expected %h/%h", i, log_adr[b+i], log_dat[b+i], ea[i], ed[i]); end
    end
    tests_run++; if (ndone - d0 !== 1 || errflag !== 1'b0) begin tests_failed++; $display("FAIL basic_done_err: done count %0d err %b expected 1/0", ndone - d0, errflag); end
  endtask

  task automatic test_len_zero;
    int b, d0, n;
    delay = 1; b = nwr; d0 = ndone;
    do_start(6'd0);
    tests_run++; if (busy !== 1'b1 || cyc !== 1'b0) begin tests_failed++; $display("FAIL len0_k0: busy=%b cyc=%b expected 1/0", busy, cyc); end
    @(negedge clk);
    tests_run++; if (cyc !== 1'b1 || adr !== 7'h00 || dat !== 32'h1) begin tests_failed++; $display("FAIL len0_commit_bus: cyc=%b %h/%h expected 1 00/00000001", cyc, adr, dat); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL len0_done_latency: got %0d expected 2", n); end
    @(negedge clk);
    tests_run++; if (nwr - b !== 1 || log_adr[b] !== 7'h00 || log_dat[b] !== 32'h1) begin tests_failed++; $display("FAIL len0_writes: count %0d first %h/%h expected 1 00/00000001", nwr - b, log_adr[b], log_dat[b]); end
    tests_run++; if (ndone - d0 !== 1) begin tests_failed++; $display("FAIL len0_done_count: got %0d expected 1", ndone - d0); end
  endtask

  task automatic test_error;
    int b, d0, n;
    delay = 1; b = nwr; d0 = ndone; err_at = ntx + 1;
    do_start(6'd3);
    n = 0;
    while (errflag !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (errflag !== 1'b1) begin tests_failed++; $display("FAIL err_flag: got %b expected 1", errflag); end
    tests_run++; if (busy !== 1'b0 || cyc !== 1'b0) begin tests_failed++; $display("FAIL err_abort: busy=%b cyc=%b expected 0/0", busy, cyc); end
    repeat (6) @(negedge clk);
    tests_run++; if (nwr - b !== 1 || ndone - d0 !== 0) begin tests_failed++; $display("FAIL err_no_commit: writes %0d dones %0d expected 1/0", nwr - b, ndone - d0); end
    tests_run++; if (errflag !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", errflag); end
    err_at = -1;
  endtask

  task automatic test_clamp;
    int b;
    logic ok;
    for (int i = 3; i < 32; i++) load_entry(5'(i), {7'h40 + 7'(i), 18'(i * 3)});
    delay = 0; b = nwr;
    do_start(6'd40);
    wait_idle(ok);
    tests_run++; if (ok !== 1'b1 || nwr - b !== 33) begin tests_failed++; $display("FAIL clamp_count: idle %b writes %0d expected 1/33", ok, nwr - b); end
    tests_run++; if (log_adr[b+3] !== 7'h43 || log_dat[b+3] !== 32'd9) begin tests_failed++; $display("FAIL clamp_entry3: got %h/%h expected 43/00000009", log_adr[b+3], log_dat[b+3]); end
    tests_run++; if (log_adr[b+31] !== 7'h5F || log_dat[b+31] !== 32'd93) begin tests_failed++; $display("FAIL clamp_entry31: got %h/%h expected 5f/0000005d", log_adr[b+31], log_dat[b+31]); end
    tests_run++; if (log_adr[b+32] !== 7'h00 || log_dat[b+32] !== 32'h1) begin tests_failed++; $display("FAIL clamp_commit: got %h/%h expected 00/00000001", log_adr[b+32], log_dat[b+32]); end
  endtask

  task automatic test_busy_ignore;
    int b, d0;
    logic ok;
    delay = 2; b = nwr; d0 = ndone;
    do_start(6'd3);
    tests_run++; if (errflag !== 1'b0) begin tests_failed++; $display("FAIL busy_err_cleared: got %b expected 0", errflag); end
    repeat (4) @(negedge clk);
    start = 1'b1; tbl_wr = 1'b1; tbl_adr = 5'd1; tbl_dat = {7'h7F, 18'h2AAAA};
    @(negedge clk);
    start = 1'b0; tbl_wr = 1'b0;
    wait_idle(ok);
    tests_run++; if (ok !== 1'b1 || nwr - b !== 4 || ndone - d0 !== 1) begin tests_failed++; $display("FAIL busy_seq: idle %b writes %0d dones %0d expected 1/4/1", ok, nwr - b, ndone - d0); end
    tests_run++; if (log_adr[b+1] !== 7'h08 || log_dat[b+1] !== 32'h0003_FFFF) begin tests_failed++; $display("FAIL busy_entry1: got %h/%h expected 08/0003ffff", log_adr[b+1], log_dat[b+1]); end
    repeat (5) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_not_queued: got %b expected 0", busy); end
    b = nwr;
    do_start(6'd2);
    wait_idle(ok);
    tests_run++; if (nwr - b !== 3 || log_adr[b+1] !== 7'h08 || log_dat[b+1] !== 32'h0003_FFFF || log_adr[b+2] !== 7'h00) begin tests_failed++; $display("FAIL busy_table_kept: writes %0d e1 %h/%h last %h expected 3 08/0003ffff 00", nwr - b, log_adr[b+1], log_dat[b+1], log_adr[b+2]); end
  endtask

  task automatic test_reset_mid;
    int b, n;
    logic ok;
    no_ack = 1;
    do_start(6'd3);
    n = 0;
    while (cyc !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (cyc !== 1'b1) begin tests_failed++; $display("FAIL rstmid_cyc_rise: got %b expected 1", cyc); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++; if ({cyc, stb, busy} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_async_drop: got %b expected 000", {cyc, stb, busy}); end
    @(negedge clk);
    rst = 1'b0; no_ack = 0; delay = 1; b = nwr;
    @(negedge clk);
    do_start(6'd3);
    wait_idle(ok);
    tests_run++; if (nwr - b !== 4 || log_adr[b] !== 7'h04 || log_dat[b] !== 32'h0000_0123 || log_adr[b+3] !== 7'h00) begin tests_failed++; $display("FAIL rstmid_replay: writes %0d first %h/%h last %h expected 4 04/00000123 00", nwr - b, log_adr[b], log_dat[b], log_adr[b+3]); end
  endtask

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    logic ok;
    no_ack = 1;
    do_start(6'd1);
    n = 0;
    while (cyc !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (cyc === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL timeout_cycles: got %0d expected 16", n); end
    tests_run++; if (errflag !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_err: err=%b busy=%b expected 1/0", errflag, busy); end
    no_ack = 0; delay = 1;
    do_start(6'd1);
    tests_run++; if (errflag !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_clear: got %b expected 0", errflag); end
    wait_idle(ok);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_error();
    test_busy_ignore();
    test_clamp();
    test_reset_mid();
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
